// File: rtl/wb_burst_ram_slave.sv
// Single-port on-chip RAM behind a Wishbone B4 slave port.
// Classic cycles plus registered-feedback incrementing bursts (linear, wrap4/8/16).
module wb_burst_ram_slave #(
  parameter int Dw        = 32,
  parameter int SELw      = Dw / 8,
  parameter int Aw        = 32,
  parameter int MEM_Aw    = 10,
  parameter int MEM_WORDS = 2 ** MEM_Aw,
  parameter int TAGw      = 3,
  parameter int CTIw      = 3,
  parameter int BTEw      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   sa_adr_i,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic [TAGw-1:0] sa_tag_i,
  input  logic            sa_we_i,
  input  logic            sa_cyc_i,
  input  logic            sa_stb_i,
  input  logic [CTIw-1:0] sa_cti_i,
  input  logic [BTEw-1:0] sa_bte_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o
);

  localparam logic [CTIw-1:0] CTI_INCR = CTIw'(2);
  localparam logic [CTIw-1:0] CTI_EOB  = CTIw'(7);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_n;
  // One extra counter bit so a linear burst running past the top is seen as out of range.
  logic [MEM_Aw:0]   cnt, cnt_n;
  logic              ack_n, err_n, dat_load;
  logic [MEM_Aw-1:0] adr_idx, rd_idx;
  logic              req, adr_oor, cnt_oor;
  logic [Dw-1:0]     mem [MEM_WORDS];
  logic              unused_tag;

  assign req        = sa_cyc_i & sa_stb_i;
  assign adr_idx    = sa_adr_i[MEM_Aw-1:0];
  assign adr_oor    = (sa_adr_i >= Aw'(MEM_WORDS)) || (|(sa_adr_i >> MEM_Aw));
  assign cnt_oor    = cnt >= (MEM_Aw+1)'(MEM_WORDS);
  assign sa_rty_o   = 1'b0;
  assign unused_tag = ^sa_tag_i;

  // Wrap modes only touch the low field, so they never carry into the range bit.
  function automatic logic [MEM_Aw:0] nxt(input logic [MEM_Aw:0] a, input logic [BTEw-1:0] bte);
    logic [MEM_Aw:0] r;
    r = a;
    case (bte)
      BTEw'(1): r[1:0] = a[1:0] + 2'd1;
      BTEw'(2): r[2:0] = a[2:0] + 3'd1;
      BTEw'(3): r[3:0] = a[3:0] + 4'd1;
      default:  r      = a + 1'b1;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sa_ack_o <= 1'b0;
      sa_err_o <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sa_ack_o <= ack_n;
      sa_err_o <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    dat_load = 1'b0;
    rd_idx   = adr_idx;
    case (state)
      IDLE: begin
        // A response pending this cycle always drops first: classic access is 2 cycles.
        if (req && !sa_ack_o && !sa_err_o) begin
          if (adr_oor) begin
            err_n = 1'b1;
          end else begin
            ack_n    = 1'b1;
            dat_load = 1'b1;
            if (sa_cti_i == CTI_INCR) begin
              state_n = BURST;
              cnt_n   = nxt({1'b0, adr_idx}, sa_bte_i);
            end
          end
        end
      end
      BURST: begin
        if (sa_ack_o && req && sa_cti_i != CTI_EOB) begin
          if (cnt_oor) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            ack_n    = 1'b1;
            dat_load = 1'b1;
            rd_idx   = cnt[MEM_Aw-1:0];
            cnt_n    = nxt(cnt, sa_bte_i);
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sa_dat_o <= '0;
    else if (dat_load) sa_dat_o <= mem[rd_idx];
  end

  // Writes land on the acknowledged cycle using the master's current address.
  always_ff @(posedge clk) begin
    if (sa_ack_o && req && sa_we_i && !adr_oor) begin
      for (int b = 0; b < SELw; b++) begin
        if (sa_sel_i[b]) mem[adr_idx][b*8 +: 8] <= sa_dat_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed bench for wb_burst_ram_slave: classic, partial, burst, overrun and reset cases.
module tb_wb_burst_ram_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  tag = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_o;
  logic        ack, err, rty;

  int checks = 0;
  int errors = 0;

  logic        c_ack1, c_err1, c_ack2, c_err2;
  logic [31:0] c_dat1;
  logic        got_ack [16];
  logic        got_err [16];
  logic [31:0] got_dat [16];
  logic        after_ack, after_err;

  wb_burst_ram_slave dut (
    .clk(clk), .reset(reset),
    .sa_adr_i(adr), .sa_dat_i(dat_i), .sa_sel_i(sel), .sa_tag_i(tag),
    .sa_we_i(we), .sa_cyc_i(cyc), .sa_stb_i(stb), .sa_cti_i(cti), .sa_bte_i(bte),
    .sa_dat_o(dat_o), .sa_ack_o(ack), .sa_err_o(err), .sa_rty_o(rty)
  );

  always #5 clk = ~clk;

  task automatic classic(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; dat_i = d; cti = 3'b000; bte = 2'b00;
    @(posedge clk); #1;
    c_ack1 = ack; c_err1 = err; c_dat1 = dat_o;
    @(posedge clk); #1;
    c_ack2 = ack; c_err2 = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic burst_read(input logic [31:0] start, input logic [1:0] b, input int n);
    int wrap;
    logic aborted;
    wrap = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : (b == 2'b11) ? 16 : 0;
    aborted = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf; adr = start; cti = 3'b010; bte = b;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      got_ack[k] = ack; got_err[k] = err; got_dat[k] = dat_o;
      if (err) aborted = 1'b1;
      if (aborted) begin
        cyc = 1'b0; stb = 1'b0;
      end else begin
        if (wrap == 0) adr = start + k;
        else adr = (start & ~(wrap - 1)) | ((start + k) & (wrap - 1));
        cti = (k == n - 1) ? 3'b111 : 3'b010;
      end
    end
    @(posedge clk); #1;
    after_ack = ack; after_err = err;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0 || rty !== 1'b0) begin
      errors++;
      $display("FAIL reset: ack=%b err=%b dat=%h rty=%b, required 0 0 00000000 0", ack, err, dat_o, rty);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_classic();
    classic(32'd5, 1'b1, 4'hf, 32'hDEADBEEF);
    checks++;
    if (c_ack1 !== 1'b1 || c_err1 !== 1'b0 || c_ack2 !== 1'b0) begin
      errors++;
      $display("FAIL classic_write_ack: ack=%b err=%b next_ack=%b, required 1 0 0", c_ack1, c_err1, c_ack2);
    end
    classic(32'd5, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_ack1 !== 1'b1 || c_dat1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL classic_read: ack=%b dat=%h, required 1 deadbeef", c_ack1, c_dat1);
    end
  endtask

  task automatic test_partial();
    classic(32'd5, 1'b1, 4'b0010, 32'h0000AB00);
    classic(32'd5, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_ack1 !== 1'b1 || c_dat1 !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL partial_write: ack=%b dat=%h, required 1 deadabef", c_ack1, c_dat1);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) classic(i, 1'b1, 4'hf, i);
    classic(32'd1022, 1'b1, 4'hf, 32'h3FE);
    classic(32'd1023, 1'b1, 4'hf, 32'h3FF);
  endtask

  task automatic test_linear();
    logic [31:0] exp_d [4];
    exp_d = '{32'd8, 32'd9, 32'd10, 32'd11};
    burst_read(32'd8, 2'b00, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_ack[k] !== 1'b1 || got_err[k] !== 1'b0 || got_dat[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL linear_beat%0d: ack=%b err=%b dat=%h, required 1 0 %h", k, got_ack[k], got_err[k], got_dat[k], exp_d[k]);
      end
    end
    checks++;
    if (after_ack !== 1'b0) begin
      errors++;
      $display("FAIL linear_end: ack=%b, required 0", after_ack);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp4 [4];
    logic [31:0] exp8 [8];
    exp4 = '{32'd6, 32'd7, 32'd4, 32'd5};
    exp8 = '{32'd13, 32'd14, 32'd15, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
    burst_read(32'd6, 2'b01, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_ack[k] !== 1'b1 || got_dat[k] !== exp4[k]) begin
        errors++;
        $display("FAIL wrap4_beat%0d: ack=%b dat=%h, required 1 %h", k, got_ack[k], got_dat[k], exp4[k]);
      end
    end
    burst_read(32'd13, 2'b10, 8);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_ack[k] !== 1'b1 || got_dat[k] !== exp8[k]) begin
        errors++;
        $display("FAIL wrap8_beat%0d: ack=%b dat=%h, required 1 %h", k, got_ack[k], got_dat[k], exp8[k]);
      end
    end
    checks++;
    if (after_ack !== 1'b0 || after_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap8_end: ack=%b err=%b, required 0 0", after_ack, after_err);
    end
  endtask

  task automatic test_out_of_range();
    classic(32'd1023, 1'b0, 4'hf, 32'h0);
    classic(32'd1024, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_err1 !== 1'b1 || c_ack1 !== 1'b0 || c_dat1 !== 32'h3FF || c_err2 !== 1'b0 || c_ack2 !== 1'b0) begin
      errors++;
      $display("FAIL classic_oor: err=%b ack=%b dat=%h next_err=%b next_ack=%b, required 1 0 000003ff 0 0",
               c_err1, c_ack1, c_dat1, c_err2, c_ack2);
    end
    classic(32'h0001_0005, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_err1 !== 1'b1 || c_ack1 !== 1'b0) begin
      errors++;
      $display("FAIL high_bit_oor: err=%b ack=%b, required 1 0", c_err1, c_ack1);
    end
    burst_read(32'd1022, 2'b00, 4);
    checks++;
    if (got_ack[0] !== 1'b1 || got_dat[0] !== 32'h3FE || got_ack[1] !== 1'b1 || got_dat[1] !== 32'h3FF) begin
      errors++;
      $display("FAIL overrun_beats: ack0=%b dat0=%h ack1=%b dat1=%h, required 1 000003fe 1 000003ff",
               got_ack[0], got_dat[0], got_ack[1], got_dat[1]);
    end
    checks++;
    if (got_err[2] !== 1'b1 || got_ack[2] !== 1'b0 || got_err[3] !== 1'b0 || got_ack[3] !== 1'b0) begin
      errors++;
      $display("FAIL overrun_err: err2=%b ack2=%b err3=%b ack3=%b, required 1 0 0 0",
               got_err[2], got_ack[2], got_err[3], got_ack[3]);
    end
    classic(32'd1022, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_ack1 !== 1'b1 || c_dat1 !== 32'h3FE) begin
      errors++;
      $display("FAIL overrun_ram: dat=%h ack=%b, required 000003fe 1", c_dat1, c_ack1);
    end
  endtask

  task automatic test_reset_mid_burst();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hf; adr = 32'd20; dat_i = 32'hAAAA0000;
    cti = 3'b010; bte = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL wburst_beat0: ack=%b, required 1", ack);
    end
    @(posedge clk); #1;
    adr = 32'd21; dat_i = 32'hBBBB0000;
    #3 reset = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0) begin
      errors++;
      $display("FAIL wburst_reset: ack=%b err=%b dat=%h, required 0 0 00000000", ack, err, dat_o);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    classic(32'd21, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_ack1 !== 1'b1 || c_dat1 !== 32'd21) begin
      errors++;
      $display("FAIL wburst_beat2_unwritten: ack=%b dat=%h, required 1 00000015", c_ack1, c_dat1);
    end
    classic(32'd20, 1'b0, 4'hf, 32'h0);
    checks++;
    if (c_ack1 !== 1'b1 || c_dat1 !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL wburst_beat1_written: ack=%b dat=%h, required 1 aaaa0000", c_ack1, c_dat1);
    end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_partial();
    preload();
    test_linear();
    test_wrap();
    test_out_of_range();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
